// File: rtl/sc_datapath.sv
// sc_datapath: single-cycle RV32I-subset core with private instruction/data memories and register file
module sc_imem #(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] instruction_memory [0:DEPTH-1];
  always_ff @(posedge clk) if (we) instruction_memory[addr] <= wdata;
  assign rdata = instruction_memory[addr];
endmodule

module sc_dmem #(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] data_memory [0:DEPTH-1];
  always_ff @(posedge clk) if (we) data_memory[addr] <= wdata;
  assign rdata = data_memory[addr];
endmodule

module sc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] reg_file [0:31];
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 32; i++) reg_file[i] <= '0;
    else if (we && wa != 5'd0) reg_file[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : reg_file[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : reg_file[ra2];
endmodule

module sc_datapath #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  logic [31:0] pc, pc_next, pc4, inst, rs1_v, rs2_v, rdata, wd, op_b, alu;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic signed [31:0] sra_v;
  logic [6:0] opcode, f7;
  logic [2:0] f3, alu_f3;
  logic r_ok, i_ok, is_r, is_i, is_lw, is_sw, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic alt, take, eq, lt, ltu, rf_we;
  sc_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) inst_mem1 (
    .clk(clk), .we(1'b0), .addr(pc[IAW+1:2]), .wdata(32'd0), .rdata(inst)
  );
  sc_regfile rf1 (
    .clk(clk), .rst(rst), .we(rf_we), .ra1(inst[19:15]), .ra2(inst[24:20]),
    .wa(inst[11:7]), .wd(wd), .rd1(rs1_v), .rd2(rs2_v)
  );
  sc_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) dm1 (
    .clk(clk), .we(is_sw & rst), .addr(alu[DAW+1:2]), .wdata(rs2_v), .rdata(rdata)
  );
  assign opcode = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign imm_i = {{21{inst[31]}}, inst[30:20]};
  assign imm_s = {{21{inst[31]}}, inst[30:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  // Only the funct7 encodings RV32I defines are accepted; anything else falls through as a NOP
  assign r_ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
  assign i_ok = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
  assign is_r = opcode == 7'b0110011 && r_ok;
  assign is_i = opcode == 7'b0010011 && i_ok;
  assign is_lw = opcode == 7'b0000011 && f3 == 3'b010;
  assign is_sw = opcode == 7'b0100011 && f3 == 3'b010;
  assign is_br = opcode == 7'b1100011 && f3[2:1] != 2'b01;
  assign is_lui = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign is_jal = opcode == 7'b1101111;
  assign is_jalr = opcode == 7'b1100111 && f3 == 3'b000;
  assign alu_f3 = (is_r | is_i) ? f3 : 3'b000;
  assign alt = inst[30] & (is_r | (is_i & f3 == 3'b101));
  assign op_b = is_r ? rs2_v : is_sw ? imm_s : imm_i;
  // Kept in its own signed net so the arithmetic shift is not demoted to unsigned by the mux
  assign sra_v = $signed(rs1_v) >>> op_b[4:0];
  always_comb begin
    case (alu_f3)
      3'b000:  alu = alt ? rs1_v - op_b : rs1_v + op_b;
      3'b001:  alu = rs1_v << op_b[4:0];
      3'b010:  alu = {31'd0, $signed(rs1_v) < $signed(op_b)};
      3'b011:  alu = {31'd0, rs1_v < op_b};
      3'b100:  alu = rs1_v ^ op_b;
      3'b101:  alu = alt ? sra_v : rs1_v >> op_b[4:0];
      3'b110:  alu = rs1_v | op_b;
      default: alu = rs1_v & op_b;
    endcase
  end
  assign eq = rs1_v == rs2_v;
  assign lt = $signed(rs1_v) < $signed(rs2_v);
  assign ltu = rs1_v < rs2_v;
  assign take = f3[2:1] == 2'b00 ? eq ^ f3[0] : f3[1] ? ltu ^ f3[0] : lt ^ f3[0];
  assign pc4 = pc + 32'd4;
  assign wd = is_lw ? rdata : is_lui ? imm_u : is_auipc ? pc + imm_u : (is_jal | is_jalr) ? pc4 : alu;
  assign rf_we = rst & (is_r | is_i | is_lw | is_lui | is_auipc | is_jal | is_jalr);
  assign pc_next = is_jal ? pc + imm_j : is_jalr ? (rs1_v + imm_i) & ~32'd1 : (is_br & take) ? pc + imm_b : pc4;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc <= '0;
    else pc <= pc_next;
endmodule

// File: tb/tb_sc_datapath.sv
// tb_sc_datapath: program-level scoreboard bench for the single-cycle core
module tb_sc_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  logic [31:0] p[$];

  sc_datapath dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // kind: 0 = register, 1 = data memory word, 2 = pc
  task automatic want(input string tag, input int kind, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain;
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, e.kind == 0 ? dut.rf1.reg_file[e.idx] : e.kind == 1 ? dut.dm1.data_memory[e.idx] : dut.pc, e.val);
    end
  endtask

  task automatic load(input logic [31:0] prog[$]);
    for (int i = 0; i < 256; i++) dut.inst_mem1.instruction_memory[i] = 32'd0;
    for (int i = 0; i < prog.size(); i++) dut.inst_mem1.instruction_memory[i] = prog[i];
  endtask

  task automatic run(input int n);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic want_prog1;
    want("p1_x6", 0, 6, 32'h24);
    want("p1_dmem1", 1, 1, 32'h24);
    want("p1_x7", 0, 7, 32'h24);
    want("p1_dmem2", 1, 2, 32'h14);
    want("p1_x5_skipped", 0, 5, 32'h0);
    want("p1_x4_auipc", 0, 4, 32'h1014);
    want("p1_pc", 2, 0, 32'h24);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dut.dm1.data_memory[i] = 32'd0;
    dut.dm1.data_memory[0] = 32'd5;
    dut.dm1.data_memory[1] = 32'd10;
    dut.dm1.data_memory[2] = 32'd20;
    dut.dm1.data_memory[3] = 32'd30;
    dut.dm1.data_memory[4] = 32'd40;
    p = '{32'h02400313, 32'h00602223, 32'h00402383, 32'h00730463, 32'h00001297, 32'h00001217};
    load(p);
    #2 rst = 1'b0;
    #1;
    want("rst_pc", 2, 0, 32'h0);
    want("rst_x6", 0, 6, 32'h0);
    want("rst_dmem1_kept", 1, 1, 32'd10);
    drain();

    want_prog1();
    run(8);
    drain();

    run(3);
    rst = 1'b0;
    #1;
    want("midrst_pc", 2, 0, 32'h0);
    want("midrst_x6", 0, 6, 32'h0);
    want("midrst_x7", 0, 7, 32'h0);
    want("midrst_dmem1", 1, 1, 32'h24);
    drain();
    want_prog1();
    run(8);
    drain();

    p = '{32'h00500013, 32'h000000B3};
    load(p);
    want("x0_stays0", 0, 0, 32'h0);
    want("add_x0_x0", 0, 1, 32'h0);
    want("x0_pc", 2, 0, 32'h8);
    run(2);
    drain();

    p = '{32'hFFF00093, 32'h00100113, 32'h00109463, 32'h00700193,
          32'h0020C463, 32'h00900213, 32'h0020E463, 32'h00B00293};
    load(p);
    want("bne_not_taken", 0, 3, 32'h7);
    want("blt_taken", 0, 4, 32'h0);
    want("bltu_not_taken", 0, 5, 32'hB);
    want("br_pc", 2, 0, 32'h24);
    run(8);
    drain();

    p = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h008000EF, 32'h00100313, 32'h00308167};
    load(p);
    want("jal_link", 0, 1, 32'h14);
    want("jal_pc", 2, 0, 32'h18);
    run(5);
    drain();
    want("jalr_pc", 2, 0, 32'h16);
    want("jalr_link", 0, 2, 32'h1C);
    repeat (1) @(posedge clk);
    #1;
    drain();
    want("pc_lowbits_ignored", 0, 6, 32'h1);
    want("pc_after_odd", 2, 0, 32'h1A);
    repeat (1) @(posedge clk);
    #1;
    drain();

    p = '{32'h800000B7, 32'h00100113, 32'h402081B3, 32'h4020D233, 32'h0020B2B3, 32'hFFFFFFFF};
    load(p);
    want("sub_wrap", 0, 3, 32'h7FFFFFFF);
    want("sra_sign", 0, 4, 32'hC0000000);
    want("sltu_zero", 0, 5, 32'h0);
    want("undef_no_reg", 0, 6, 32'h0);
    want("undef_no_store", 1, 0, 32'd5);
    want("undef_pc", 2, 0, 32'h1C);
    run(7);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sc_datapath.md
Name: sc_datapath

Overview:
Single-cycle RV32I-subset processor datapath with its own instruction memory, data memory and register file. Every instruction is fetched, decoded, executed and retired in one clock cycle. It is the top of the CPU core. It has no external bus; benches load programs and data, and check results, through fixed hierarchical names.

Parameters:
IMEM_DEPTH, 256, number of 32-bit words in instruction memory
DMEM_DEPTH, 256, number of 32-bit words in data memory

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-low

Behaviour:
- Mandatory internal hierarchy, used by benches for preload and checking:
  - inst_mem1.instruction_memory[0:IMEM_DEPTH-1] (32-bit words)
  - dm1.data_memory[0:DMEM_DEPTH-1] (32-bit words)
  - rf1.reg_file[0:31] (32-bit)
  - Plain unpacked arrays, writable from the bench at any time.
- Reset (rst low, asynchronous):
  - PC = 0; reg_file[0..31] = 0.
  - Memories are NOT cleared; preloaded contents survive reset.
  - While rst is low, no register-file or data-memory writes occur.
- Fetch:
  - Combinational read of instruction = instruction_memory[PC[log2(IMEM_DEPTH)+1:2]].
  - PC[1:0] ignored; index wraps modulo depth.
- Register file:
  - Two combinational read ports (rs1 = inst[19:15], rs2 = inst[24:20]).
  - One write port on posedge clk (rd = inst[11:7]).
  - x0 always reads 0; writes to x0 discarded.
  - A read in the same cycle as a write returns the old value.
- Data memory:
  - Word-addressed by ALU result [log2(DMEM_DEPTH)+1:2]; low two bits ignored; wraps modulo depth.
  - Combinational read; synchronous write on posedge when the store is enabled.
  - Only full-word accesses.
- Supported instructions (others execute as NOP: PC+4, no writes):
  - R-type (0110011): add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - I-type ALU (0010011): addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - lw (0000011, funct3 010): rd = mem[rs1+imm].
  - sw (0100011, funct3 010): mem[rs1+imm] = rs2.
  - Branches (1100011): beq, bne, blt, bge, bltu, bgeu; if taken, PC = PC + B-imm, else PC + 4.
  - lui (0110111): rd = U-imm.
  - auipc (0010111): rd = PC + U-imm.
  - jal (1101111): rd = PC+4; PC = PC + J-imm.
  - jalr (1100111): rd = PC+4; PC = (rs1 + I-imm) & ~1.
- Immediates sign-extended per RV32I (I, S, B, J); U-imm = inst[31:12] << 12.
- Arithmetic: 32-bit, wraps with no overflow trap; shift amount = low 5 bits.
- Next PC registered on posedge; exactly one instruction retires per cycle after reset release.
- Exactly one instruction retires per cycle while rst is high; mid-program reset returns PC to 0 immediately.

Test Plan:
- Program: imem[0..5] = 02400313, 00602223, 00402383, 00730463, 00001297, 00001217; dmem[0..4] = 5, 10, 20, 30, 40; release reset and run 8 cycles.
  - Then: x6 = 0x24, dmem[1] = 0x24, x7 = 0x24, dmem[2] = 0x14 unchanged.
  - beq is taken, so x5 = 0 (skipped) and x4 = 0x1014.
- Assert rst low mid-run: PC returns to 0 asynchronously and reg_file is cleared. Re-running reproduces identical results; dmem keeps prior stores.
- addi x0,x0,5 followed by add x1,x0,x0: x0 stays 0 and x1 = 0.
- bne not taken (equal operands): next PC = PC+4. blt with -1 vs 1: taken. bltu with 0xFFFFFFFF vs 1: not taken.
- jal x1,+8 at PC 0x10: x1 = 0x14, PC = 0x18. jalr x2,3(x1): PC = 0x16, x2 = PC+4.
- sub/sra/sltu on 0x80000000 and 1: results 0x7FFFFFFF, 0xC0000000, 0. Undefined opcode: no state change except PC+4.
